// File: rtl/window_rotate_gen.sv
// Descriptor-window address rotator: walks a WIN x WIN window, rotates offsets by main_dir, emits addresses.
// Optional WINDOW_ROTATE_CLAMP_EN: clamp out-of-image samples to the border instead of emitting address 0.
module window_rotate_gen #(
    parameter int    COORD_W   = 9,
    parameter int    LOG2_W    = 9,
    parameter int    IMG_H     = 512,
    parameter int    ADDR_W    = 18,
    parameter int    N_DIR     = 36,
    parameter int    DIR_W     = 6,
    parameter int    WIN       = 16,
    parameter int    FRAC      = 8,
    parameter string TRIG_FILE = "trig_lut.mem"
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    output logic                         start_ready_o,
    input  logic [COORD_W-1:0]           kp_x_i,
    input  logic [COORD_W-1:0]           kp_y_i,
    input  logic [DIR_W-1:0]             main_dir_i,
    input  logic                         half_res_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [ADDR_W-1:0]            out_addr_o,
    output logic [2*$clog2(WIN)-1:0]     out_idx_o,
    output logic                         out_oob_o,
    output logic                         out_last_o,
    output logic                         done_o,
    output logic                         dir_err_o
);
    localparam int LW     = $clog2(WIN);
    localparam int IW     = 2 * LW;
    localparam int TW     = FRAC + 2;
    localparam int PW     = COORD_W + FRAC + 4;
    localparam int CW     = COORD_W + 2;
    localparam int STAGES = 4;
    localparam logic signed [LW:0]   HALF     = (LW+1)'(WIN / 2);
    localparam logic signed [PW-1:0] RND      = PW'(1 << (FRAC - 1));
    localparam logic [IW-1:0]        LAST_IDX = '1;
    localparam logic [DIR_W-1:0]     NDIR_L   = DIR_W'(N_DIR);

    if (TRIG_FILE == "" || (WIN & (WIN - 1)) != 0 || WIN < 4 || FRAC < 8) begin : g_bad_cfg
        $error("window_rotate_gen: unsupported configuration");
    end

    // Quarter-wave of cos(10 deg * m) in Q8; the trig table is folded from it for the 36-bin layout.
    function automatic int qtr(input int m);
        case (m)
            0: qtr = 256;  1: qtr = 252;  2: qtr = 241;  3: qtr = 222;  4: qtr = 196;
            5: qtr = 165;  6: qtr = 128;  7: qtr = 88;   8: qtr = 44;   default: qtr = 0;
        endcase
    endfunction

    function automatic logic signed [TW-1:0] cos_q(input int k);
        int m;
        int v;
        m = k % 36;
        if (m <= 9)       v = qtr(m);
        else if (m <= 18) v = -qtr(18 - m);
        else if (m <= 27) v = -qtr(m - 18);
        else              v = qtr(36 - m);
        return TW'(v * (1 << (FRAC - 8)));
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state_q;
    logic                 start_ready_q, done_q, dir_err_q, half_q;
    logic [IW-1:0]        cnt_q;
    logic [COORD_W-1:0]   kp_x_q, kp_y_q;
    logic [DIR_W-1:0]     dir_q;
    logic [STAGES:1]      vld_q;
    logic                 en, issue, dir_bad;

    logic signed [LW:0]    dx_d, dy_d, dx_q, dy_q;
    logic signed [TW-1:0]  c_d, s_d, c_q, s_q;
    logic signed [PW-1:0]  pxc_d, pys_d, pxs_d, pyc_d, pxc_q, pys_q, pxs_q, pyc_q;
    logic signed [PW-1:0]  sx, sy;
    logic signed [CW-1:0]  x_d, y_d, x3_q, y3_q;
    logic                  oob3_d, oob3_q, oob_q;
    logic [IW-1:0]         idx1_q, idx2_q, idx3_q, idx_q;
    logic                  last1_q, last2_q, last3_q, last_q;
    logic [ADDR_W-1:0]     addr_d, addr_q;
    int                    sh, wlim, hlim, xi, yi;

    assign en      = !vld_q[STAGES] || out_ready_i;
    assign issue   = (state_q == RUN) && en;
    assign dir_bad = main_dir_i >= NDIR_L;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            start_ready_q <= 1'b1;
            done_q        <= 1'b0;
            dir_err_q     <= 1'b0;
            cnt_q         <= '0;
            kp_x_q        <= '0;
            kp_y_q        <= '0;
            dir_q         <= '0;
            half_q        <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            dir_err_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    kp_x_q        <= kp_x_i;
                    kp_y_q        <= kp_y_i;
                    half_q        <= half_res_i;
                    dir_q         <= dir_bad ? '0 : main_dir_i;
                    dir_err_q     <= dir_bad;
                    cnt_q         <= '0;
                    start_ready_q <= 1'b0;
                    state_q       <= RUN;
                end
                RUN: if (en) begin
                    if (cnt_q == LAST_IDX) state_q <= DRAIN;
                    else                   cnt_q   <= cnt_q + IW'(1);
                end
                DRAIN: if (vld_q[STAGES] && last_q && out_ready_i) begin
                    done_q        <= 1'b1;
                    start_ready_q <= 1'b1;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        sh     = LOG2_W - (half_q ? 1 : 0);
        wlim   = 1 << sh;
        hlim   = IMG_H >> (half_q ? 1 : 0);
        dx_d   = $signed({1'b0, cnt_q[LW-1:0]}) - HALF;
        dy_d   = $signed({1'b0, cnt_q[IW-1:LW]}) - HALF;
        c_d    = cos_q(int'(dir_q));
        s_d    = cos_q(int'(dir_q) + 27);
        pxc_d  = PW'(dx_q) * PW'(c_q);
        pys_d  = PW'(dy_q) * PW'(s_q);
        pxs_d  = PW'(dx_q) * PW'(s_q);
        pyc_d  = PW'(dy_q) * PW'(c_q);
        sx     = pxc_q - pys_q + RND;
        sy     = pxs_q + pyc_q + RND;
        x_d    = $signed({2'b00, kp_x_q}) + CW'(sx >>> FRAC);
        y_d    = $signed({2'b00, kp_y_q}) + CW'(sy >>> FRAC);
        oob3_d = (int'(x_d) < 0) || (int'(x_d) >= wlim) || (int'(y_d) < 0) || (int'(y_d) >= hlim);
        xi     = int'(x3_q);
        yi     = int'(y3_q);
`ifdef WINDOW_ROTATE_CLAMP_EN
        if (xi < 0) xi = 0; else if (xi >= wlim) xi = wlim - 1;
        if (yi < 0) yi = 0; else if (yi >= hlim) yi = hlim - 1;
        addr_d = ADDR_W'((yi << sh) + xi);
`else
        addr_d = oob3_q ? '0 : ADDR_W'((yi << sh) + xi);
`endif
    end

    // Whole pipeline advances only on the global enable so a stalled beat is held, never dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            vld_q  <= '0;
            dx_q   <= '0;  dy_q  <= '0;  c_q   <= '0;  s_q   <= '0;
            pxc_q  <= '0;  pys_q <= '0;  pxs_q <= '0;  pyc_q <= '0;
            x3_q   <= '0;  y3_q  <= '0;  oob3_q <= 1'b0; oob_q <= 1'b0;
            idx1_q <= '0;  idx2_q <= '0; idx3_q <= '0; idx_q <= '0;
            last1_q <= 1'b0; last2_q <= 1'b0; last3_q <= 1'b0; last_q <= 1'b0;
            addr_q <= '0;
        end else if (en) begin
            vld_q   <= {vld_q[STAGES-1:1], issue};
            dx_q    <= dx_d;   dy_q  <= dy_d;   c_q   <= c_d;   s_q   <= s_d;
            idx1_q  <= cnt_q;  last1_q <= (cnt_q == LAST_IDX);
            pxc_q   <= pxc_d;  pys_q <= pys_d;  pxs_q <= pxs_d; pyc_q <= pyc_d;
            idx2_q  <= idx1_q; last2_q <= last1_q;
            x3_q    <= x_d;    y3_q  <= y_d;    oob3_q <= oob3_d;
            idx3_q  <= idx2_q; last3_q <= last2_q;
            addr_q  <= addr_d; oob_q <= oob3_q;
            idx_q   <= idx3_q; last_q <= last3_q;
        end
    end

    assign start_ready_o = start_ready_q;
    assign out_valid_o   = vld_q[STAGES];
    assign out_addr_o    = addr_q;
    assign out_idx_o     = idx_q;
    assign out_oob_o     = oob_q;
    assign out_last_o    = last_q;
    assign done_o        = done_q;
    assign dir_err_o     = dir_err_q;
endmodule

// File: tb/tb_window_rotate_gen.sv
// Directed bench for window_rotate_gen: vector table of whole windows plus stall, mid-run start and reset sequences.
module tb_window_rotate_gen;
    logic        clk, rst_n, start, start_ready, half_res;
    logic [8:0]  kp_x, kp_y;
    logic [5:0]  main_dir;
    logic        out_valid, out_ready, out_oob, out_last, done, dir_err;
    logic [17:0] out_addr;
    logic [7:0]  out_idx;

    int total = 0;
    int bad   = 0;

    window_rotate_gen dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .start_ready_o(start_ready),
        .kp_x_i(kp_x), .kp_y_i(kp_y), .main_dir_i(main_dir), .half_res_i(half_res),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_addr_o(out_addr),
        .out_idx_o(out_idx), .out_oob_o(out_oob), .out_last_o(out_last),
        .done_o(done), .dir_err_o(dir_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kx; int ky; int dir; bit half;
        int tidx; int addr; bit oob; bit last;
        int stall; bit mid;
    } vec_t;

`ifdef WINDOW_ROTATE_CLAMP_EN
    localparam int A_TOP = 3, A_RIGHT = 157695, A_HALF = 4607, A_BOT = 261739;
`else
    localparam int A_TOP = 0, A_RIGHT = 0, A_HALF = 0, A_BOT = 0;
`endif

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic run_win(input vec_t v);
        int lat, nxt, cyc, seq_err, stall_err;
        bit seen_done;
        logic [17:0] sa;
        logic [7:0]  si;
        logic        so, sl;
        @(negedge clk);
        chk("start_ready idle", start_ready, 1);
        kp_x = 9'(v.kx); kp_y = 9'(v.ky); main_dir = 6'(v.dir); half_res = v.half; start = 1'b1;
        @(negedge clk);
        start = 1'b0; kp_x = 9'h1ff; kp_y = 9'h1ff; main_dir = 6'd5; half_res = ~v.half;
        chk("dir_err pulse", dir_err, (v.dir >= 36) ? 1 : 0);
        chk("start_ready busy", start_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("first valid latency", lat, 4);
        nxt = 0; cyc = 0; seq_err = 0; stall_err = 0; seen_done = 1'b0;
        while (cyc < 2000) begin
            start = 1'b0;
            if (done) seen_done = 1'b1;
            if (out_valid) begin
                if (nxt == v.stall) begin
                    sa = out_addr; si = out_idx; so = out_oob; sl = out_last;
                    out_ready = 1'b0;
                    repeat (10) begin
                        @(negedge clk);
                        if (!out_valid || out_addr != sa || out_idx != si || out_oob != so || out_last != sl)
                            stall_err++;
                    end
                    out_ready = 1'b1;
                    cyc += 10;
                end
                if (out_idx != 8'(nxt) || out_last != (nxt == 255)) seq_err++;
                if (nxt == v.tidx) begin
                    chk("addr", out_addr, v.addr);
                    chk("oob", out_oob, v.oob);
                    chk("last", out_last, v.last);
                end
                if (v.mid && nxt == 50) begin
                    start = 1'b1; kp_x = 9'd7; kp_y = 9'd7; main_dir = 6'd9;
                end
                nxt++;
                if (out_last) break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        @(negedge clk);
        chk("done pulse", done, 1);
        chk("beat count", nxt, 256);
        chk("idx order", seq_err, 0);
        chk("early done", seen_done, 0);
        if (v.stall >= 0) chk("stall hold", stall_err, 0);
    endtask

    vec_t vt[14];

    initial begin
        int k, stray;
        vt[0]  = '{100, 100, 0,  1'b0, 0,   47196,   1'b0, 1'b0, 40, 1'b0};
        vt[1]  = '{100, 100, 0,  1'b0, 255, 54891,   1'b0, 1'b1, -1, 1'b1};
        vt[2]  = '{100, 100, 9,  1'b0, 0,   47212,   1'b0, 1'b0, -1, 1'b0};
        vt[3]  = '{50,  50,  0,  1'b1, 0,   10794,   1'b0, 1'b0, -1, 1'b0};
        vt[4]  = '{50,  50,  0,  1'b1, 255, 14649,   1'b0, 1'b1, -1, 1'b0};
        vt[5]  = '{3,   3,   0,  1'b0, 8,   A_TOP,   1'b1, 1'b0, -1, 1'b0};
        vt[6]  = '{3,   3,   0,  1'b0, 136, 1539,    1'b0, 1'b0, -1, 1'b0};
        vt[7]  = '{100, 100, 40, 1'b0, 0,   47196,   1'b0, 1'b0, -1, 1'b0};
        vt[8]  = '{100, 100, 18, 1'b0, 0,   55404,   1'b0, 1'b0, -1, 1'b0};
        vt[9]  = '{100, 100, 27, 1'b0, 0,   55388,   1'b0, 1'b0, -1, 1'b0};
        vt[10] = '{100, 100, 4,  1'b0, 255, 56421,   1'b0, 1'b1, -1, 1'b0};
        vt[11] = '{510, 300, 0,  1'b0, 255, A_RIGHT, 1'b1, 1'b1, -1, 1'b0};
        vt[12] = '{250, 10,  0,  1'b1, 255, A_HALF,  1'b1, 1'b1, -1, 1'b0};
        vt[13] = '{100, 508, 0,  1'b0, 255, A_BOT,   1'b1, 1'b1, -1, 1'b0};

        rst_n = 1'b0; start = 1'b0; kp_x = '0; kp_y = '0; main_dir = '0; half_res = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset start_ready", start_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_addr", out_addr, 0);
        chk("reset out_idx", out_idx, 0);
        chk("reset done", done, 0);
        chk("reset dir_err", dir_err, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_win(vt[i]);

        // Reset in the middle of a window: no done pulse, no further beats.
        @(negedge clk);
        kp_x = 9'd100; kp_y = 9'd100; main_dir = 6'd0; half_res = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(out_valid && out_idx == 8'd100) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("reached idx 100", out_idx, 100);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset out_valid", out_valid, 0);
        chk("midreset out_addr", out_addr, 0);
        chk("midreset out_idx", out_idx, 0);
        chk("midreset start_ready", start_ready, 1);
        rst_n = 1'b1;
        stray = 0;
        repeat (300) begin
            @(negedge clk);
            if (done || out_valid) stray++;
        end
        chk("no activity after reset", stray, 0);

        run_win(vt[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/window_rotate_gen.md
Name: window_rotate_gen

Overview:
- Parametrised successor of the descriptor-window address rotator.
- On one start handshake it sequences every sample of a WIN x WIN descriptor window around a keypoint, rotates each offset by the keypoint's main orientation using a cos/sin LUT, and emits one gradient-memory address per beat on a valid/ready stream.
- Sits between orientation assignment (main_dir producer) and the descriptor histogram builder.
- Replaces per-direction offset ROMs with arithmetic rotation, and adds sequencing, backpressure and bounds checking.

Parameters:
- COORD_W, 9, width of keypoint x/y coordinates (unsigned).
- LOG2_W, 9, log2 of full-resolution image width; the row shift.
- IMG_H, 512, full-resolution image height in rows.
- ADDR_W, 18, output address width.
- N_DIR, 36, number of orientation bins.
- DIR_W, 6, main_dir width.
- WIN, 16, window side in samples; power of two, at least 4.
- FRAC, 8, fractional bits of the LUT entries.
- TRIG_FILE, "trig_lut.mem", ROM init file. Entry k = {cos, sin} of 2*pi*k/N_DIR, each signed FRAC+2 bits, rounded to nearest.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-low reset.
- start, in, 1, request a new window.
- start_ready, out, 1, high only in IDLE.
- kp_x, in, COORD_W, keypoint column.
- kp_y, in, COORD_W, keypoint row.
- main_dir, in, DIR_W, orientation bin.
- half_res, in, 1, 1 = half-resolution octave: row shift is LOG2_W-1, bounds are halved.
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, consumer accepts the beat.
- out_addr, out, ADDR_W, rotated sample address.
- out_idx, out, 2*log2(WIN), sample index, row-major.
- out_oob, out, 1, sample lies outside the image.
- out_last, out, 1, final sample of the window.
- done, out, 1, one-cycle pulse after the last beat is accepted.
- dir_err, out, 1, one-cycle pulse when main_dir >= N_DIR was latched.

Behaviour:
- Reset: all outputs 0 except start_ready=1. FSM goes to IDLE and the pipeline is flushed. Reset mid-run abandons the window with no done pulse.
- FSM states:
  - IDLE: start_ready=1. If start=1, latch kp_x, kp_y, main_dir, half_res, clear the sample counter i, go to RUN.
  - RUN: issue one sample per enabled cycle. After issuing i = WIN*WIN-1, go to DRAIN.
  - DRAIN: wait until the beat carrying out_last is accepted, pulse done, go to IDLE.
- start while not in IDLE is ignored. Latched inputs are immune to later input changes.
- main_dir >= N_DIR: the window uses bin 0, and dir_err pulses in the cycle after acceptance.
- Offsets for sample i: dx = (i mod WIN) - WIN/2, dy = (i div WIN) - WIN/2; range -WIN/2 .. WIN/2-1.
- Rotation:
  - rx = (dx*c - dy*s + 2^(FRAC-1)) >>> FRAC.
  - ry = (dx*s + dy*c + 2^(FRAC-1)) >>> FRAC.
  - All arithmetic is signed with no intermediate overflow; size products to COORD_W+FRAC+4 bits.
- Coordinates: X = kp_x + rx, Y = kp_y + ry, signed COORD_W+2 bits.
  - Bounds: W = 2^(LOG2_W - half_res), H = IMG_H >> half_res.
  - out_oob = (X<0) | (X>=W) | (Y<0) | (Y>=H).
- Address: in bounds, out_addr = (Y << shift) + X, truncated to ADDR_W. Out of bounds: see Optional Feature.
- Pipeline, 4 stages: S1 LUT read/offset gen, S2 multiply, S3 round/add/bound, S4 address/output register.
- Latency: the first beat asserts out_valid 4 cycles after the start handshake.
- Backpressure: a global enable = !out_valid | out_ready.
  - When out_valid=1 and out_ready=0, every stage and the counter freeze.
  - out_addr, out_idx, out_oob and out_last are held stable; no beat is lost or duplicated.
- Exactly WIN*WIN beats per window, with out_idx 0..WIN*WIN-1 in order.
- Back-to-back: start may be accepted in the cycle after done.

Optional Feature:
- Macro: WINDOW_ROTATE_CLAMP_EN.
- Defined: out-of-range X and Y are clamped independently to [0, W-1] and [0, H-1]. The address is formed from the clamped values and out_oob is still set.
- Undefined: out-of-range samples emit out_addr = 0 with out_oob = 1.

Test Plan:
- Full res, kp=(100,100), dir=0: idx0 -> out_addr=47196; idx255 -> out_addr=54891, out_last=1; done one cycle after acceptance; exactly 256 beats; out_valid first rises 4 cycles after start.
- kp=(100,100), dir=9 (90 deg, c=0, s=256): idx0 -> X=108, Y=92, out_addr=47212.
- half_res=1, kp=(50,50), dir=0: idx0 -> out_addr=10794; idx255 -> (57<<8)+57=14649.
- kp=(3,3), dir=0, idx8 (dx=0, dy=-8): out_oob=1; out_addr=3 with CLAMP_EN, 0 without; idx136 (dx=0, dy=0) -> out_oob=0, out_addr=1539.
- Hold out_ready low for 10 cycles at idx 40: outputs stable throughout, no gaps in idx, 256 beats total.
- main_dir=40 -> dir_err pulses and addresses match dir 0. Start asserted mid-run is ignored. Reset at idx 100 -> outputs 0, start_ready=1 next cycle, no done pulse.
